// File: rtl/divu_hilo_unit.sv
// Multi-cycle restoring divider with HI/LO result registers and mfhi/mflo readout.
// One quotient bit per cycle; signed divides run on magnitudes and fix signs at the end.
module divu_hilo_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic             op_valid,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hilo_out
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned RW = WIDTH + 1;
    localparam logic [CW-1:0] CntInit = CW'(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             sign_q, sign_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hilo_out_q, hilo_out_d;

    logic             in_signed;
    logic [WIDTH-1:0] in_dvd_mag;
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH+1:0] rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign busy        = (state_q != StIdle);
    assign stall       = op_valid && (op != 2'b11) && busy;
    assign done        = (state_q == StFin);
    assign div_by_zero = done && (divisor_q == '0);
    assign hilo_out    = hilo_out_q;

    assign in_signed  = (SIGNED_EN != 0) && signed_mode;
    assign in_dvd_mag = (in_signed && dividend[WIDTH-1]) ? -dividend : dividend;

    assign dvd_neg = sign_q && dividend_q[WIDTH-1];
    assign dvs_neg = sign_q && divisor_q[WIDTH-1];
    assign dvs_mag = dvs_neg ? -divisor_q : divisor_q;

    // The quotient register starts as the dividend magnitude and shifts its MSB into the remainder.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign rem_ge = (rem_sh >= {2'b00, dvs_mag});

    assign quo_fix = (dvd_neg ^ dvs_neg) ? -quo_q : quo_q;
    assign rem_fix = dvd_neg ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        sign_d     = sign_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        hilo_out_d = hilo_out_q;

        unique case (state_q)
            StIdle: begin
                if (op_valid) begin
                    case (op)
                        2'b00: begin
                            dividend_d = dividend;
                            divisor_d  = divisor;
                            sign_d     = in_signed;
                            rem_d      = '0;
                            quo_d      = in_dvd_mag;
                            if (divisor == '0) begin
                                state_d = StFin;
                            end else begin
                                state_d = StCalc;
                                cnt_d   = CntInit;
                            end
                        end
                        2'b10:   hilo_out_d = hi_q;
                        2'b01:   hilo_out_d = lo_q;
                        default: ;
                    endcase
                end
            end
            StCalc: begin
                rem_d = rem_ge ? RW'(rem_sh - {2'b00, dvs_mag}) : rem_sh[WIDTH:0];
                quo_d = {quo_q[WIDTH-2:0], rem_ge};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                if (divisor_q == '0) begin
                    lo_d = '1;
                    hi_d = dividend_q;
                end else begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            sign_q     <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            hilo_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            sign_q     <= sign_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            hilo_out_q <= hilo_out_d;
        end
    end

endmodule
